// File: rtl/display_pkg.sv
// display_pkg: shared seven-segment constants and the single-digit encoder.
//   SEG_NUM    : segments per digit
//   SEG_CODES  : active-low common-anode codes for 0..9, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK  : all segments off
//   seg_encode : BCD digit -> segment code (non-decimal values show blank)
package display_pkg;

    localparam int SEG_NUM = 7;

    localparam logic [SEG_NUM-1:0] SEG_CODES [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam logic [SEG_NUM-1:0] SEG_BLANK = 7'h7F;

    function automatic logic [SEG_NUM-1:0] seg_encode(input logic [3:0] d);
        return (d > 4'd9) ? SEG_BLANK : SEG_CODES[d];
    endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: combinational double-dabble binary to packed BCD converter.
//   WIDTH  : binary input width
//   DIGITS : number of BCD digits produced
//   bin_i  : binary value
//   bcd_o  : DIGITS x 4 bits of BCD, digit 0 (ones) in bits [3:0]
module bin_to_bcd #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic [WIDTH-1:0]    bin_i,
    output logic [DIGITS*4-1:0] bcd_o
);

    always_comb begin
        bcd_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            for (int d = 0; d < DIGITS; d++)
                bcd_o[4*d +: 4] = (bcd_o[4*d +: 4] > 4'd4) ? bcd_o[4*d +: 4] + 4'd3 : bcd_o[4*d +: 4];
            bcd_o = {bcd_o[DIGITS*4-2:0], bin_i[i]};
        end
    end

endmodule

// File: rtl/mod_counter_display.sv
// mod_counter_display: modulo-N up/down counter with load, cascade tc and decimal seven-segment readout.
//   clk_1Hz  : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   en       : count enable
//   up_dn    : 1 = up, 0 = down
//   load     : synchronous load, overrides en
//   load_val : value to load, clamped to MODULO-1
//   count    : registered binary count
//   tc       : terminal count, drives the next stage's en
//   seg_led  : DIGITS x 7 active-low segments, digit 0 = ones in bits [6:0]
// Define LEADING_ZERO_BLANK_EN to blank digits above the most-significant nonzero digit.
module mod_counter_display
    import display_pkg::*;
#(
    parameter  int MODULO = 60,
    parameter  int DIGITS = 2,
    localparam int WIDTH  = $clog2(MODULO)
) (
    input  logic                      clk_1Hz,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      up_dn,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_val,
    output logic [WIDTH-1:0]          count,
    output logic                      tc,
    output logic [DIGITS*SEG_NUM-1:0] seg_led
);

    if (MODULO < 2 || 10 ** DIGITS < MODULO) begin : g_param_check
        $error("mod_counter_display: need MODULO >= 2 and 10**DIGITS >= MODULO");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0]    count_q, count_d;
    logic [DIGITS*4-1:0] bcd;
    logic [DIGITS-1:0]   nz_at_or_above;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = (load_val > MAX) ? MAX : load_val;
        else if (en)
            count_d = up_dn ? ((count_q == MAX) ? '0 : count_q + 1'b1)
                            : ((count_q == '0) ? MAX : count_q - 1'b1);
    end

    always_ff @(posedge clk_1Hz or negedge rst_n)
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;

    assign count = count_q;

    // Held low during reset so a cascaded stage cannot see a spurious enable.
    assign tc = rst_n & en & ~load & (up_dn ? (count_q == MAX) : (count_q == '0));

    bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_bcd (
        .bin_i(count_q),
        .bcd_o(bcd)
    );

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [SEG_NUM-1:0] enc;
        assign enc = seg_encode(bcd[4*k +: 4]);
        // nz_at_or_above[k]: some digit at position k or higher is nonzero.
        if (k == DIGITS - 1) begin : g_top
            assign nz_at_or_above[k] = |bcd[4*k +: 4];
        end else begin : g_mid
            assign nz_at_or_above[k] = nz_at_or_above[k+1] | (|bcd[4*k +: 4]);
        end
`ifdef LEADING_ZERO_BLANK_EN
        assign seg_led[SEG_NUM*k +: SEG_NUM] = (k == 0 || nz_at_or_above[k]) ? enc : SEG_BLANK;
`else
        assign seg_led[SEG_NUM*k +: SEG_NUM] = enc;
`endif
    end

`ifndef LEADING_ZERO_BLANK_EN
    logic unused_nz;
    assign unused_nz = ^nz_at_or_above;
`endif

endmodule

// File: tb/tb_mod_counter_display.sv
// tb_mod_counter_display: directed self-checking bench for mod_counter_display (seconds, cascade and 4-digit instances).
module tb_mod_counter_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        up_dn = 1'b1;
    logic        load = 1'b0;
    logic [5:0]  load_val = '0;
    logic [5:0]  count;
    logic        tc;
    logic [13:0] seg;

    logic [5:0]  min_count;
    logic        min_tc;
    logic [13:0] min_seg;

    logic        big_load = 1'b0;
    logic [9:0]  big_val = '0;
    logic [9:0]  big_count;
    logic        big_tc;
    logic [27:0] big_seg;

    int checks = 0;
    int errors = 0;

    logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    mod_counter_display #(.MODULO(60), .DIGITS(2)) u_sec (
        .clk_1Hz(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .seg_led(seg)
    );

    mod_counter_display #(.MODULO(60), .DIGITS(2)) u_min (
        .clk_1Hz(clk), .rst_n(rst_n), .en(tc), .up_dn(1'b1), .load(1'b0),
        .load_val(6'd0), .count(min_count), .tc(min_tc), .seg_led(min_seg)
    );

    mod_counter_display #(.MODULO(1000), .DIGITS(4)) u_big (
        .clk_1Hz(clk), .rst_n(rst_n), .en(1'b0), .up_dn(1'b1), .load(big_load),
        .load_val(big_val), .count(big_count), .tc(big_tc), .seg_led(big_seg)
    );

    function automatic logic [13:0] exp2(input int v);
        return {tbl[v / 10], tbl[v % 10]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0;
        load = 1'b0;
        big_load = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++;
        if (count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++;
        if (seg !== {7'h40, 7'h40}) begin errors++; $display("FAIL reset_seg got %h want %h", seg, {7'h40, 7'h40}); end
        checks++;
        if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got %b want 0", tc); end
        checks++;
        if (big_seg !== {7'h40, 7'h40, 7'h40, 7'h40}) begin errors++; $display("FAIL reset_big_seg got %h", big_seg); end
        rst_n = 1'b1;
    endtask

    task automatic test_up();
        do_reset();
        en = 1'b1;
        up_dn = 1'b1;
        #1;
        for (int i = 0; i < 60; i++) begin
            checks++;
            if (count !== 6'(i)) begin errors++; $display("FAIL up_count got %0d want %0d", count, i); end
            checks++;
            if (tc !== (i == 59)) begin errors++; $display("FAIL up_tc at %0d got %b want %b", i, tc, i == 59); end
            checks++;
            if (seg !== exp2(i)) begin errors++; $display("FAIL up_seg at %0d got %h want %h", i, seg, exp2(i)); end
            if (i == 59) begin
                checks++;
                if (seg !== {7'h12, 7'h10}) begin errors++; $display("FAIL up_seg59 got %h want %h", seg, {7'h12, 7'h10}); end
            end
            step();
        end
        checks++;
        if (count !== 6'd0) begin errors++; $display("FAIL up_wrap got %0d want 0", count); end
    endtask

    task automatic test_down();
        do_reset();
        en = 1'b1;
        up_dn = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b1) begin errors++; $display("FAIL down_tc0 got %b want 1", tc); end
        step();
        checks++;
        if (count !== 6'd59) begin errors++; $display("FAIL down_wrap got %0d want 59", count); end
        checks++;
        if (tc !== 1'b0) begin errors++; $display("FAIL down_tc59 got %b want 0", tc); end
        step();
        checks++;
        if (count !== 6'd58) begin errors++; $display("FAIL down_58 got %0d want 58", count); end
    endtask

    task automatic test_load();
        do_reset();
        en = 1'b1;
        up_dn = 1'b1;
        load = 1'b1;
        load_val = 6'd62;  // above range; 75 does not fit in the 6-bit port
        #1;
        checks++;
        if (tc !== 1'b0) begin errors++; $display("FAIL load_tc got %b want 0", tc); end
        step();
        checks++;
        if (count !== 6'd59) begin errors++; $display("FAIL load_clamp got %0d want 59", count); end
        checks++;
        if (tc !== 1'b0) begin errors++; $display("FAIL load_tc59 got %b want 0", tc); end
        load_val = 6'd7;
        step();
        checks++;
        if (count !== 6'd7) begin errors++; $display("FAIL load_7 got %0d want 7", count); end
        load = 1'b0;
        en = 1'b0;
        step();
        checks++;
        if (count !== 6'd7) begin errors++; $display("FAIL hold_7 got %0d want 7", count); end
        load = 1'b1;
        load_val = 6'd59;
        step();
        load = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b0) begin errors++; $display("FAIL en_low_tc got %b want 0", tc); end
        step();
        checks++;
        if (count !== 6'd59) begin errors++; $display("FAIL en_low_hold got %0d want 59", count); end
        big_load = 1'b1;
        big_val = 10'd1023;
        step();
        big_load = 1'b0;
        checks++;
        if (big_count !== 10'd999) begin errors++; $display("FAIL big_clamp got %0d want 999", big_count); end
    endtask

    task automatic test_midreset();
        do_reset();
        load = 1'b1;
        load_val = 6'd42;
        step();
        load = 1'b0;
        en = 1'b1;
        checks++;
        if (count !== 6'd42) begin errors++; $display("FAIL mid_load got %0d want 42", count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 6'd0) begin errors++; $display("FAIL mid_reset_count got %0d want 0", count); end
        checks++;
        if (seg !== {7'h40, 7'h40}) begin errors++; $display("FAIL mid_reset_seg got %h want %h", seg, {7'h40, 7'h40}); end
        #2;
        rst_n = 1'b1;
        en = 1'b0;
    endtask

    task automatic test_cascade();
        int s;
        int m;
        logic wrap;
        do_reset();
        s = 0;
        m = 0;
        en = 1'b1;
        up_dn = 1'b1;
        for (int i = 0; i < 3600; i++) begin
            wrap = (s == 59);
            step();
            s = (s + 1) % 60;
            if (wrap) m = (m + 1) % 60;
            checks++;
            if (min_count !== 6'(m) || count !== 6'(s)) begin
                errors++;
                $display("FAIL cascade edge %0d got %0d:%0d want %0d:%0d", i, min_count, count, m, s);
            end
        end
        checks++;
        if (min_count !== 6'd0 || count !== 6'd0) begin errors++; $display("FAIL cascade_end got %0d:%0d want 0:0", min_count, count); end
        checks++;
        if (min_seg !== {7'h40, 7'h40}) begin errors++; $display("FAIL cascade_seg got %h", min_seg); end
        en = 1'b0;
    endtask

    task automatic test_big();
        logic [27:0] e7;
        logic [27:0] e305;
`ifdef LEADING_ZERO_BLANK_EN
        e7 = {7'h7F, 7'h7F, 7'h7F, 7'h78};
        e305 = {7'h7F, 7'h30, 7'h40, 7'h12};
`else
        e7 = {7'h40, 7'h40, 7'h40, 7'h78};
        e305 = {7'h40, 7'h30, 7'h40, 7'h12};
`endif
        big_load = 1'b1;
        big_val = 10'd7;
        step();
        checks++;
        if (big_seg !== e7) begin errors++; $display("FAIL big_seg7 got %h want %h", big_seg, e7); end
        big_val = 10'd305;
        step();
        checks++;
        if (big_seg !== e305) begin errors++; $display("FAIL big_seg305 got %h want %h", big_seg, e305); end
        big_val = 10'd999;
        step();
        checks++;
        if (big_seg !== {7'h40, 7'h10, 7'h10, 7'h10} && big_seg !== {7'h7F, 7'h10, 7'h10, 7'h10}) begin
            errors++;
            $display("FAIL big_seg999 got %h", big_seg);
        end
        big_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up();
        test_down();
        test_load();
        test_midreset();
        test_cascade();
        test_big();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
